// File: rtl/nios_setup_nios2f_cpu_mul_pkg.sv
// Shared definitions for the sequential 32x32 multiplier built around a
// registered 16x16 partial-product cell: op encodings, FSM states, cell latency.
package nios_setup_nios2f_cpu_mul_pkg;

  localparam int CELL_LAT = 1;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXSS = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PASS1   = 3'd1,
    ST_PASS2   = 3'd2,
    ST_COMBINE = 3'd3,
    ST_DONE    = 3'd4
  } mul_state_e;

endpackage

// File: rtl/nios_setup_nios2f_cpu_mul_combine.sv
// Purely combinational assembly of the partial products into the 32-bit
// result word: low word for MUL, corrected high word for the MULX variants.
module nios_setup_nios2f_cpu_mul_combine
  import nios_setup_nios2f_cpu_mul_pkg::*;
(
  input  mul_op_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_p1,
  input  logic [31:0] i_p2,
  input  logic [31:0] i_p3,
  input  logic [31:0] i_ll,
  input  logic [31:0] i_lh,
  input  logic [31:0] i_hl,
  output logic [31:0] o_result
);

  logic [31:0] w_cross;
  logic [31:0] w_mul_lo;
  logic [32:0] w_mid;
  logic [63:0] w_full;
  logic [31:0] w_u;
  logic [31:0] w_corr_a;
  logic [31:0] w_corr_b;

  always_comb begin
    w_cross  = i_p2 + i_p3;
    w_mul_lo = i_p1 + (w_cross << 16);
    // Cross-term sum keeps its carry so the unsigned high word is exact.
    w_mid    = {1'b0, i_lh} + {1'b0, i_hl};
    w_full   = {i_p1, 32'h0} + {15'h0, w_mid, 16'h0} + {32'h0, i_ll};
    w_u      = 32'(w_full >> 32);
    w_corr_a = i_a[31] ? i_b : 32'h0;
    w_corr_b = i_b[31] ? i_a : 32'h0;
    o_result = w_mul_lo;
    unique case (i_op)
      OP_MUL:    o_result = w_mul_lo;
      OP_MULXUU: o_result = w_u;
      OP_MULXSU: o_result = w_u - w_corr_a;
      OP_MULXSS: o_result = w_u - w_corr_a - w_corr_b;
      default:   o_result = w_mul_lo;
    endcase
  end

endmodule

// File: rtl/nios_setup_nios2f_cpu_mul_seq.sv
// Sequencer for the multiplier: one cell pass for MUL, two for MULX*, then a
// combine cycle and a held result. Handshake semantics: a transfer occurs on a
// rising edge where valid and ready are both high; valid never waits on ready.
module nios_setup_nios2f_cpu_mul_seq
  import nios_setup_nios2f_cpu_mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [2:0]  o_dbg_state
);

  mul_state_e  r_state;
  mul_state_e  w_next;
  mul_op_e     r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_ll;
  logic [31:0] r_lh;
  logic [31:0] r_hl;
  logic [31:0] r_result;
  logic [31:0] w_result;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_MUL;
      r_a      <= '0;
      r_b      <= '0;
      r_ll     <= '0;
      r_lh     <= '0;
      r_hl     <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op <= mul_op_e'(req_op);
            r_a  <= req_src1;
            r_b  <= req_src2;
          end
        end
        ST_PASS2: begin
          r_ll <= cell_p1;
          r_lh <= cell_p2;
          r_hl <= cell_p3;
        end
        ST_COMBINE: r_result <= w_result;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    cell_en   = 1'b0;
    cell_src1 = 32'h0;
    cell_src2 = 32'h0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = ST_PASS1;
      end
      ST_PASS1: begin
        cell_en   = 1'b1;
        cell_src1 = r_a;
        cell_src2 = r_b;
        w_next    = (r_op == OP_MUL) ? ST_COMBINE : ST_PASS2;
      end
      ST_PASS2: begin
        // High halves go through the low-half lane so cell_p1 becomes A.hi*B.hi.
        cell_en   = 1'b1;
        cell_src1 = {16'h0, r_a[31:16]};
        cell_src2 = {16'h0, r_b[31:16]};
        w_next    = ST_COMBINE;
      end
      ST_COMBINE: w_next = ST_DONE;
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  nios_setup_nios2f_cpu_mul_combine u_combine (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_p1     (cell_p1),
    .i_p2     (cell_p2),
    .i_p3     (cell_p3),
    .i_ll     (r_ll),
    .i_lh     (r_lh),
    .i_hl     (r_hl),
    .o_result (w_result)
  );

  assign rsp_result  = r_result;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nios_setup_nios2f_cpu_mul_seq.sv
// Directed bench for the sequential multiplier with a behavioural registered
// 16x16 partial-product cell and hand-computed expected products.
module tb_nios_setup_nios2f_cpu_mul_seq;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic [31:0] cell_src1;
  logic [31:0] cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1;
  logic [31:0] cell_p2;
  logic [31:0] cell_p3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] c1_seen [0:31];
  logic [31:0] c2_seen [0:31];
  logic        ce_seen [0:31];
  logic [31:0] exp_q [$];

  nios_setup_nios2f_cpu_mul_seq dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .cell_src1   (cell_src1),
    .cell_src2   (cell_src2),
    .cell_en     (cell_en),
    .cell_p1     (cell_p1),
    .cell_p2     (cell_p2),
    .cell_p3     (cell_p3),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered partial-product cell
  always_ff @(posedge clk) begin
    if (cell_en) begin
      cell_p1 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
      cell_p2 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
      cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: issue one request from IDLE and wait (bounded) for the response
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      c1_seen[lat] = cell_src1;
      c2_seen[lat] = cell_src2;
      ce_seen[lat] = cell_en;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    res = rsp_result;
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_idle_valid"}, 64'(rsp_valid), 64'd0);
  endtask

  task automatic do_test(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int lat;
    run_op(op, a, b, res, lat);
    check({tag, "_result"}, 64'(res), 64'(exp));
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    consume(tag);
  endtask

  // back-to-back vectors, req_valid held high throughout
  logic [1:0]  bb_op  [0:4] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
  logic [31:0] bb_a   [0:4] = '{32'h00000007, 32'h00010000, 32'h80000000, 32'hFFFFFFFE, 32'h12345678};
  logic [31:0] bb_b   [0:4] = '{32'h00000006, 32'h00010000, 32'h80000000, 32'h00000003, 32'h00000010};
  logic [31:0] bb_exp [0:4] = '{32'h0000002A, 32'h00000001, 32'h40000000, 32'hFFFFFFFF, 32'h23456780};

  initial begin
    logic [31:0] res;
    int lat;
    int k;
    int got;
    int cyc;
    logic accepted;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_src1  = '0;
    req_src2  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_req_ready",  64'(req_ready),   64'd1);
    check("rst_rsp_valid",  64'(rsp_valid),   64'd0);
    check("rst_cell_en",    64'(cell_en),     64'd0);
    check("rst_rsp_result", 64'(rsp_result),  64'd0);
    check("rst_state",      64'(o_dbg_state), 64'd0);

    do_test("mul_basic", 2'b00, 32'h00010003, 32'h00020005, 32'h000B000F, 3);

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
    check("mulxuu_ff_result",  64'(res), 64'hFFFFFFFE);
    check("mulxuu_ff_latency", 64'(lat), 64'd4);
    check("mulxuu_pass1_src1", 64'(c1_seen[1]), 64'hFFFFFFFF);
    check("mulxuu_pass1_en",   64'(ce_seen[1]), 64'd1);
    check("mulxuu_pass2_src1", 64'(c1_seen[2]), 64'h0000FFFF);
    check("mulxuu_pass2_src2", 64'(c2_seen[2]), 64'h0000FFFF);
    check("mulxuu_pass2_en",   64'(ce_seen[2]), 64'd1);
    check("mulxuu_comb_en",    64'(ce_seen[3]), 64'd0);
    consume("mulxuu_ff");

    do_test("mulxss_neg1x2",  2'b11, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 4);
    do_test("mulxsu_min_x2",  2'b10, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 4);
    do_test("mulxuu_small",   2'b01, 32'h00010003, 32'h00020005, 32'h00000002, 4);
    do_test("mulxss_mixed",   2'b11, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 4);
    do_test("mulxsu_big_b",   2'b10, 32'h00000002, 32'h80000000, 32'h00000001, 4);

    // consumer stall in DONE
    run_op(2'b00, 32'h00000003, 32'h00000004, res, lat);
    check("stall_first", 64'(res), 64'd12);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_rsp_valid",  64'(rsp_valid),  64'd1);
      check("stall_rsp_result", 64'(rsp_result), 64'd12);
      check("stall_req_ready",  64'(req_ready),  64'd0);
    end
    consume("stall");

    // reset while in PASS2
    @(negedge clk);
    req_op    = 2'b01;
    req_src1  = 32'hDEADBEEF;
    req_src2  = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pass2_state", 64'(o_dbg_state), 64'd2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_cell_en",   64'(cell_en),   64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    do_test("after_rst_mul", 2'b00, 32'h00010003, 32'h00020005, 32'h000B000F, 3);

    // reset coincident with an accept
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b00;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    check("rst_vs_req_state",   64'(o_dbg_state), 64'd0);
    check("rst_vs_req_cell_en", 64'(cell_en),     64'd0);

    // back-to-back with req_valid held high and consumer always ready
    @(negedge clk);
    rsp_ready = 1'b1;
    k   = 0;
    got = 0;
    cyc = 0;
    req_op    = bb_op[0];
    req_src1  = bb_a[0];
    req_src2  = bb_b[0];
    req_valid = 1'b1;
    while (got < 5 && cyc < 200) begin
      accepted = 1'b0;
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("b2b_unexpected_rsp", 64'(rsp_result), 64'h0);
        else check("b2b_result", 64'(rsp_result), 64'(exp_q.pop_front()));
        got++;
      end
      if (req_ready) begin
        check("b2b_idle_only", {62'h0, rsp_valid, cell_en}, 64'h0);
        if (req_valid) begin
          exp_q.push_back(bb_exp[k]);
          accepted = 1'b1;
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (accepted) begin
        k++;
        if (k < 5) begin
          req_op   = bb_op[k];
          req_src1 = bb_a[k];
          req_src2 = bb_b[k];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("b2b_count",    64'(got), 64'd5);
    check("b2b_accepted", 64'(k),   64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
